// File: rtl/gc_controller_mc_if.sv
`default_nettype none
// ============================================================================
// Module      : gc_controller_mc_if
// Description : Handshake bundle between the GC controller and its neighbours
//               (FTL allocator, victim selector, page-move and erase engines).
//   ini_*      : clean-block preload from the FTL during INIT
//   alloc_*    : host clean-block allocation
//   victim_*   : victim-selection handshake
//   move_*     : per-page relocation handshake
//   erase      : request_blk_clean / erase_done
//   master     : the GC controller side
//   slave      : the surrounding engines / allocator side
// Revision    : 1.0 - initial release
// ============================================================================
interface gc_controller_mc_if #(
  parameter int BLK_ADDR_W = 10,
  parameter int PG_CNT_W   = 7
);
  logic                  ini_valid;
  logic [BLK_ADDR_W-1:0] ini_addr;
  logic                  ini_full;
  logic                  alloc_req;
  logic                  alloc_ack;
  logic [BLK_ADDR_W-1:0] alloc_addr;
  logic                  alloc_fail;
  logic                  victim_req;
  logic                  victim_ack;
  logic [BLK_ADDR_W-1:0] victim_addr;
  logic [PG_CNT_W-1:0]   victim_pages;
  logic                  move_flag;
  logic                  move_done_flag;
  logic                  request_blk_clean;
  logic                  erase_done;

  modport master (
    input  ini_valid, ini_addr, alloc_req, victim_ack, victim_addr,
           victim_pages, move_done_flag, erase_done,
    output ini_full, alloc_ack, alloc_addr, alloc_fail, victim_req,
           move_flag, request_blk_clean
  );

  modport slave (
    output ini_valid, ini_addr, alloc_req, victim_ack, victim_addr,
           victim_pages, move_done_flag, erase_done,
    input  ini_full, alloc_ack, alloc_addr, alloc_fail, victim_req,
           move_flag, request_blk_clean
  );
endinterface
`default_nettype wire

// File: rtl/gc_controller_mc.sv
`default_nettype none
// ============================================================================
// Module      : gc_controller_mc
// Description : Garbage-collection controller. Keeps a circular FIFO of clean
//               block addresses, serves host allocations from it and, when
//               the clean count falls below LOW_WM (or on gc_start), reclaims
//               victim blocks (select, move valid pages, erase, recycle)
//               until HIGH_WM clean blocks are available.
// Ports       : CLK, nRST (sync, active-low)
//               gc_ini        level, INIT mode / preload enable
//               gc_start      pulse, force one GC pass
//               bus           gc_controller_mc_if.master handshake bundle
//               gc_request    GC busy
//               gc_interrupt  pulse at end of a GC run
//               request_done  pulse per reclaimed block recycled
//               clean_num     FIFO occupancy
//               gc_paused     (GC_PREEMPT_EN only) page move held for host
// Options     : `define GC_PREEMPT_EN to let host allocations pause page moves
// Revision    : 1.0 - initial release
// ============================================================================
module gc_controller_mc #(
  parameter int FIFO_SIZE_BIT_NUM = 4,
  parameter int BLK_ADDR_W        = 10,
  parameter int PG_CNT_W          = 7,
  parameter int LOW_WM            = 2,
  parameter int HIGH_WM           = 6
) (
  input  wire logic                       CLK,
  input  wire logic                       nRST,
  input  wire logic                       gc_ini,
  input  wire logic                       gc_start,
  gc_controller_mc_if.master              bus,
  output logic                            gc_request,
  output logic                            gc_interrupt,
  output logic                            request_done,
  output logic [FIFO_SIZE_BIT_NUM:0]      clean_num
`ifdef GC_PREEMPT_EN
  ,
  output logic                            gc_paused
`endif
);

  localparam int             CW      = FIFO_SIZE_BIT_NUM + 1;
  localparam int             DEPTH   = 1 << FIFO_SIZE_BIT_NUM;
  localparam logic [CW-1:0]  C_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0]  C_LOW   = CW'(LOW_WM);
  localparam logic [CW-1:0]  C_HIGH  = CW'(HIGH_WM);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_INIT   = 3'd1;
  localparam logic [2:0] S_SELECT = 3'd2;
  localparam logic [2:0] S_MOVE   = 3'd3;  // move_flag issued this cycle
  localparam logic [2:0] S_MWAIT  = 3'd4;  // waiting for move_done_flag
  localparam logic [2:0] S_ERASE  = 3'd5;
  localparam logic [2:0] S_PUSH   = 3'd6;
`ifdef GC_PREEMPT_EN
  localparam logic [2:0] S_PAUSE  = 3'd7;  // move withheld for host traffic
`endif

  logic [BLK_ADDR_W-1:0]        mem_q [DEPTH];
  logic [FIFO_SIZE_BIT_NUM-1:0] wr_q, rd_q;
  logic [CW-1:0]                clean_q, clean_d;
  logic [2:0]                   state_q, state_d;
  logic [BLK_ADDR_W-1:0]        vaddr_q, vaddr_d;
  logic [PG_CNT_W-1:0]          cnt_q, cnt_d;
  logic                         forced_q, forced_d;
  logic                         irq_q, irq_d;
  logic                         ack_q, fail_q;
  logic [BLK_ADDR_W-1:0]        aaddr_q;

  logic                  full, empty, push, pop;
  logic [BLK_ADDR_W-1:0] push_data;

  assign full  = (clean_q == C_DEPTH);
  assign empty = (clean_q == '0);

  // Preload is only taken while the FSM is quiescent, so it can never
  // collide with a recycle push from S_PUSH.
  always_comb begin
    push      = 1'b0;
    push_data = bus.ini_addr;
    if (state_q == S_PUSH) begin
      push      = !full;
      push_data = vaddr_q;
    end else if (gc_ini && bus.ini_valid && !full &&
                 (state_q == S_IDLE || state_q == S_INIT)) begin
      push = 1'b1;
    end
  end

  assign pop = bus.alloc_req && !empty;

  always_comb begin
    clean_d = clean_q;
    if (push && !pop)      clean_d = clean_q + CW'(1);
    else if (pop && !push) clean_d = clean_q - CW'(1);
  end

  // FIFO storage carries no reset; occupancy is tracked by clean_q alone.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_q] <= push_data;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      wr_q    <= '0;
      rd_q    <= '0;
      clean_q <= '0;
      ack_q   <= 1'b0;
      fail_q  <= 1'b0;
      aaddr_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      clean_q <= clean_d;
      ack_q   <= pop;
      fail_q  <= bus.alloc_req && empty;
      if (pop) aaddr_q <= mem_q[rd_q];
    end
  end

  always_comb begin
    state_d  = state_q;
    vaddr_d  = vaddr_q;
    cnt_d    = cnt_q;
    forced_d = forced_q;
    irq_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (gc_ini) begin
          state_d = S_INIT;
        end else if (clean_q < C_LOW || gc_start) begin
          state_d  = S_SELECT;
          // A forced run stops as soon as the low watermark is satisfied.
          forced_d = !(clean_q < C_LOW);
        end
      end
      S_INIT: if (!gc_ini) state_d = S_IDLE;
      S_SELECT: begin
        if (bus.victim_ack) begin
          vaddr_d = bus.victim_addr;
          cnt_d   = bus.victim_pages;
          state_d = (bus.victim_pages == '0) ? S_ERASE : S_MOVE;
        end
      end
      S_MOVE: state_d = S_MWAIT;
      S_MWAIT: begin
        if (bus.move_done_flag) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == PG_CNT_W'(1)) begin
            state_d = S_ERASE;
          end else begin
`ifdef GC_PREEMPT_EN
            state_d = pop ? S_PAUSE : S_MOVE;
`else
            state_d = S_MOVE;
`endif
          end
        end
      end
`ifdef GC_PREEMPT_EN
      S_PAUSE: state_d = S_MOVE;
`endif
      S_ERASE: if (bus.erase_done) state_d = S_PUSH;
      S_PUSH: begin
        if (clean_d >= C_HIGH || (forced_q && !(clean_d < C_LOW))) begin
          state_d = S_IDLE;
          irq_d   = 1'b1;
        end else begin
          state_d = S_SELECT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q  <= S_IDLE;
      vaddr_q  <= '0;
      cnt_q    <= '0;
      forced_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      vaddr_q  <= vaddr_d;
      cnt_q    <= cnt_d;
      forced_q <= forced_d;
      irq_q    <= irq_d;
    end
  end

  assign bus.ini_full          = full;
  assign bus.alloc_ack         = ack_q;
  assign bus.alloc_addr        = aaddr_q;
  assign bus.alloc_fail        = fail_q;
  assign bus.victim_req        = (state_q == S_SELECT);
  assign bus.move_flag         = (state_q == S_MOVE);
  assign bus.request_blk_clean = (state_q == S_ERASE);
  assign request_done          = (state_q == S_PUSH);
  assign gc_request            = (state_q != S_IDLE) && (state_q != S_INIT);
  assign gc_interrupt          = irq_q;
  assign clean_num             = clean_q;
`ifdef GC_PREEMPT_EN
  assign gc_paused             = (state_q == S_PAUSE);
`endif

endmodule
`default_nettype wire

// File: tb/tb_gc_controller_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_gc_controller_mc
// Description : Self-checking bench for gc_controller_mc (depth 8, LOW_WM 2,
//               HIGH_WM 5): table of INIT/alloc vectors, then hand-written
//               GC runs, forced zero-page runs with concurrent allocation,
//               pointer wrap and reset in the middle of a page move.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gc_controller_mc;
  localparam int FSB = 3;
  localparam int AW  = 10;
  localparam int PW  = 7;

  logic           CLK = 1'b0;
  logic           nRST = 1'b0;
  logic           gc_ini = 1'b0;
  logic           gc_start = 1'b0;
  logic           gc_request, gc_interrupt, request_done;
  logic [FSB:0]   clean_num;
`ifdef GC_PREEMPT_EN
  logic           gc_paused;
`endif

  gc_controller_mc_if #(.BLK_ADDR_W(AW), .PG_CNT_W(PW)) bus ();

  gc_controller_mc #(
    .FIFO_SIZE_BIT_NUM(FSB), .BLK_ADDR_W(AW), .PG_CNT_W(PW),
    .LOW_WM(2), .HIGH_WM(5)
  ) dut (
    .CLK(CLK), .nRST(nRST), .gc_ini(gc_ini), .gc_start(gc_start), .bus(bus),
    .gc_request(gc_request), .gc_interrupt(gc_interrupt),
    .request_done(request_done), .clean_num(clean_num)
`ifdef GC_PREEMPT_EN
    , .gc_paused(gc_paused)
`endif
  );

  always #5 CLK = ~CLK;

  int n_pass = 0;
  int n_checks = 0;
  int irq_cnt = 0;

  typedef struct {
    logic          gi;
    logic          iv;
    logic [AW-1:0] ia;
    logic          ar;
    logic [FSB:0]  e_clean;
    logic          e_full;
    logic          e_ack;
    logic [AW-1:0] e_addr;
    logic          e_fail;
  } vec_t;

  vec_t tab[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Advance one clock; sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
    if (gc_interrupt) irq_cnt++;
  endtask

  function automatic vec_t mk(input logic gi, input logic iv, input logic [AW-1:0] ia,
                              input logic ar, input int ec, input logic ef,
                              input logic ea, input logic [AW-1:0] eaddr, input logic efl);
    vec_t v;
    v.gi = gi; v.iv = iv; v.ia = ia; v.ar = ar; v.e_clean = (FSB+1)'(ec);
    v.e_full = ef; v.e_ack = ea; v.e_addr = eaddr; v.e_fail = efl;
    return v;
  endfunction

  // Answer one victim request; returns after the PUSH cycle is reached.
  task automatic serve(input logic [AW-1:0] a, input int pages);
    bit seen;
    int moves;
    seen = 0;
    moves = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (bus.victim_req) seen = 1;
      else step();
    end
    check("victim_req_seen", 32'(seen), 32'd1);
    bus.victim_ack = 1'b1; bus.victim_addr = a; bus.victim_pages = PW'(pages);
    step();
    bus.victim_ack = 1'b0;
    if (pages == 0) check("erase_after_zero_page_ack", 32'(bus.request_blk_clean), 32'd1);
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (bus.request_blk_clean) seen = 1;
      else if (bus.move_flag) begin
        moves++;
        step();
        bus.move_done_flag = 1'b1;
        step();
        bus.move_done_flag = 1'b0;
      end else step();
    end
    check("erase_req_seen", 32'(seen), 32'd1);
    check("move_pulses", 32'(moves), 32'(pages));
    bus.erase_done = 1'b1;
    step();
    bus.erase_done = 1'b0;
    check("request_done", 32'(request_done), 32'd1);
  endtask

  initial begin
    logic [AW-1:0] fpop [4];
    logic [AW-1:0] drain [5];
    bit            seen;
    fpop  = '{10'h020, 10'h030, 10'h031, 10'h032};
    drain = '{10'h033, 10'h040, 10'h041, 10'h042, 10'h043};

    bus.ini_valid = 0; bus.ini_addr = '0; bus.alloc_req = 0; bus.victim_ack = 0;
    bus.victim_addr = '0; bus.victim_pages = '0; bus.move_done_flag = 0; bus.erase_done = 0;

    // Preload 9 addresses (9th dropped), then drain to empty and fail once.
    tab.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 9; i++)
      tab.push_back(mk(1, 1, AW'(16 + i), 0, (i < 8) ? i + 1 : 8, i >= 7, 0, 0, 0));
    tab.push_back(mk(1, 0, 0, 1, 7, 0, 1, 10'h010, 0));
    tab.push_back(mk(1, 0, 0, 1, 6, 0, 1, 10'h011, 0));
    tab.push_back(mk(1, 0, 0, 0, 6, 0, 0, 0, 0));
    for (int i = 0; i < 6; i++)
      tab.push_back(mk(1, 0, 0, 1, 5 - i, 0, 1, AW'(18 + i), 0));
    tab.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 1));
    tab.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));

    step();
    step();
    check("rst_clean", 32'(clean_num), 0);
    check("rst_gc_request", 32'(gc_request), 0);
    check("rst_ack_fail", 32'({bus.alloc_ack, bus.alloc_fail, bus.ini_full}), 0);
    nRST = 1'b1;

    for (int k = 0; k < tab.size(); k++) begin
      gc_ini = tab[k].gi; bus.ini_valid = tab[k].iv; bus.ini_addr = tab[k].ia;
      bus.alloc_req = tab[k].ar;
      step();
      check($sformatf("v%0d_clean", k), 32'(clean_num), 32'(tab[k].e_clean));
      check($sformatf("v%0d_full", k), 32'(bus.ini_full), 32'(tab[k].e_full));
      check($sformatf("v%0d_ack", k), 32'(bus.alloc_ack), 32'(tab[k].e_ack));
      check($sformatf("v%0d_fail", k), 32'(bus.alloc_fail), 32'(tab[k].e_fail));
      if (tab[k].e_ack) check($sformatf("v%0d_addr", k), 32'(bus.alloc_addr), 32'(tab[k].e_addr));
    end
    bus.ini_valid = 0; bus.alloc_req = 0;

    // Watermark GC: one clean block, four 3-page victims, stop at 5.
    bus.ini_valid = 1; bus.ini_addr = 10'h020;
    step();
    bus.ini_valid = 0;
    check("gc_pre_clean", 32'(clean_num), 1);
    gc_ini = 0;
    irq_cnt = 0;
    for (int v = 0; v < 4; v++) begin
      serve(AW'(10'h030 + v), 3);
      step();
      check($sformatf("gc_clean_%0d", v), 32'(clean_num), 32'(2 + v));
    end
    check("gc_irq_count", 32'(irq_cnt), 1);
    check("gc_request_end", 32'(gc_request), 0);
    step();
    check("gc_stays_idle", 32'({gc_request, bus.victim_req}), 0);

    // Forced zero-page runs with an allocation in each PUSH cycle.
    for (int v = 0; v < 4; v++) begin
      gc_start = 1;
      step();
      gc_start = 0;
      serve(AW'(10'h040 + v), 0);
      bus.alloc_req = 1;
      step();
      bus.alloc_req = 0;
      check($sformatf("f%0d_clean", v), 32'(clean_num), 5);
      check($sformatf("f%0d_ack", v), 32'(bus.alloc_ack), 1);
      check($sformatf("f%0d_addr", v), 32'(bus.alloc_addr), 32'(fpop[v]));
      check($sformatf("f%0d_irq", v), 32'(gc_interrupt), 1);
    end

    // Drain across the pointer wrap with GC held off by INIT.
    gc_ini = 1;
    for (int i = 0; i < 5; i++) begin
      bus.alloc_req = 1;
      step();
      check($sformatf("drain%0d_addr", i), 32'(bus.alloc_addr), 32'(drain[i]));
      check($sformatf("drain%0d_clean", i), 32'(clean_num), 32'(4 - i));
    end
    bus.alloc_req = 0;

    // Reset in the middle of a page move.
    bus.ini_valid = 1; bus.ini_addr = 10'h050;
    step();
    bus.ini_valid = 0;
    gc_ini = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (bus.victim_req) seen = 1;
      else step();
    end
    check("rm_victim_req", 32'(seen), 1);
    bus.victim_ack = 1; bus.victim_addr = 10'h060; bus.victim_pages = 7'd3;
    step();
    bus.victim_ack = 0;
    check("rm_move_flag", 32'(bus.move_flag), 1);
`ifdef GC_PREEMPT_EN
    step();
    bus.move_done_flag = 1; bus.alloc_req = 1;
    step();
    bus.move_done_flag = 0; bus.alloc_req = 0;
    check("pre_paused", 32'(gc_paused), 1);
    check("pre_move_withheld", 32'(bus.move_flag), 0);
    step();
    check("pre_move_resumed", 32'({bus.move_flag, gc_paused}), 32'b10);
`endif
    nRST = 0; gc_ini = 1;
    step();
    check("rm_move_flag_clr", 32'(bus.move_flag), 0);
    check("rm_gc_request_clr", 32'(gc_request), 0);
    check("rm_clean_clr", 32'(clean_num), 0);
    nRST = 1;
    step();
    check("rm_after_release", 32'({gc_request, bus.victim_req}), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
`default_nettype wire
